instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the instruction-memory read port. Owns the program counter, drives it to
//  the word-indexed instruction memory, captures the returned word with its PC in a small
//  prefetch buffer and presents it to decode over a valid/ready handshake.
//  Sits between instruction memory and the IF/ID stage. Branch/jump redirects arrive from later stages.
// PARAMETERS
//  DEPTH     2   prefetch buffer entries (power of two, >=2)
//  PC_W      32  program counter width; PC is a word index: +1 per instruction
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  imem_pc        out  PC_W  fetch address to instruction memory (= internal PC register)
//  imem_instr     in   32    instruction word returned combinationally for imem_pc
//  redirect_valid in   1     take redirect_pc this cycle (branch/jump resolved)
//  redirect_pc    in   PC_W  new fetch address
//  if_valid       out  1     buffer head holds a valid instruction
//  if_instr       out  32    head instruction word
//  if_pc          out  PC_W  head instruction PC
//  if_pc_next     out  PC_W  if_pc + 1 (for branch-target and link computation)
//  id_ready       in   1     decode accepts head this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC, buffer empty, if_valid=0, if_instr=0,
//    if_pc=0, if_pc_next=1. imem_pc=RESET_PC.
//  - pop  = if_valid & id_ready. push = !redirect_valid & (count<DEPTH | pop).
//  - On push: entry {imem_pc, imem_instr} written at tail; pc <= pc+1 (mod 2^PC_W, wraps to 0).
//    No push: pc holds, imem_pc holds.
//  - Latency: word fetched in cycle N is visible at if_* in cycle N+1 (no combinational bypass).
//  - Full buffer with pop in same cycle: push and pop both occur, count unchanged.
//  - Empty buffer: if_valid=0; if_* outputs hold the last value (don't-care for decode).
//  - Redirect (highest priority): next edge pc <= redirect_pc, buffer cleared (count=0,
//    pointers reset), no push. A pop in the redirect cycle is still a completed handshake.
//    if_valid=0 the cycle after redirect; first redirected instruction appears one cycle later.
//  - Back-to-back redirects: last one wins; buffer stays empty.
//  - Reset asserted mid-operation: all state returns to reset values immediately.
//  - No range check on PC; out-of-range memory contents are passed through unchanged.
// STRUCTURE
//  - cpu_pkg: WORD_W=32, PC_W, RESET_PC, NOP_INSTR=32'h0000_0000, fetch_entry_t {pc, instr}.
//  - Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push/pop/flush,
//    count, full/empty; head exposed combinationally. Top holds PC register and control only.
// TESTING
//  1 Reset then id_ready=1: if_valid rises 1 cycle after release; if_pc 0,1,2,3 on consecutive
//    cycles; if_instr at pc0 = 32'h01095020, if_pc_next=1.
//  2 id_ready=0 from reset: imem_pc goes 0,1,2 then holds at 2; if_pc holds 0; release
//    id_ready -> if_pc 0,1,2 contiguous, no duplicate or skipped PC.
//  3 Redirect to 11 while streaming: next cycle if_valid=0, imem_pc=11; following cycle
//    if_pc=11, if_instr=32'h12120000; no stale pre-redirect entry ever valid.
//  4 Redirect while full and id_ready=0: buffer flushed, count=0, fetch resumes at target.
//  5 redirect_pc=32'hFFFF_FFFF, id_ready=1: if_pc FFFF_FFFF then 0; if_pc_next=0 at wrap.
//  6 rst_n pulsed low mid-stream (between edges): if_valid=0 and imem_pc=0 immediately;
//    after release sequence restarts at pc 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants.
// Holds word/PC widths, reset PC, NOP encoding and the fetch_entry_t bundle.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0]   RESET_PC  = '0;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t; head is read combinationally.
// Ports: clk, rst_n, push/pop/flush, wr_data in; head, count, full, empty out.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full buffer is legal only when the head leaves
  // in the same cycle; the slot being freed is the one written.
  assign w_push = push & (!full | pop);
  assign w_pop  = pop & !empty;

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads imem, buffers {pc,instr} for decode.
// Ports: clk, rst_n, imem_pc/imem_instr, redirect_valid/pc, if_* out, id_ready in.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_pc_next,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] r_pc;
  fetch_entry_t    r_hold;

  fetch_entry_t    w_wr;
  fetch_entry_t    w_head;
  fetch_entry_t    w_out;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign imem_pc  = r_pc;
  assign if_valid = (w_count != '0);

  assign w_pop  = if_valid & id_ready;
  assign w_push = !redirect_valid & (!w_full | w_pop);

  assign w_wr.pc    = r_pc;
  assign w_wr.instr = imem_instr;

  // With the buffer empty, decode sees the last word it accepted.
  assign w_out      = w_empty ? r_hold : w_head;
  assign if_pc      = w_out.pc;
  assign if_instr   = w_out.instr;
  assign if_pc_next = w_out.pc + PC_W'(1);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (redirect_valid),
    .wr_data (w_wr),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  // A pop during a redirect still completes, so the hold copy tracks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold.pc    <= '0;
      r_hold.instr <= NOP_INSTR;
    end else if (w_pop) begin
      r_hold <= w_head;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit.
// Stimulus queues expected fetches; a negedge monitor checks each handshake.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_next;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic        id_ready;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_unit #(
    .DEPTH    (2),
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_next     (if_pc_next),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    case (pc)
      32'd0:   return 32'h0109_5020;
      32'd11:  return 32'h1212_0000;
      default: return {16'hC0DE, pc[15:0]};
    endcase
  endfunction

  assign imem_instr = mem_word(imem_pc);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc      = pc;
    e.instr   = mem_word(pc);
    e.pc_next = pc + 32'd1;
    exp_q.push_back(e);
  endtask

  // Waits until the scoreboard holds at most n entries; runs at posedge+1.
  task automatic wait_q(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() <= n) break;
    end
    chk("wait_q", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_next", if_pc_next, 32'h1);
    chk("rst_imem_pc", imem_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got pc %h expected none at %0t",
                 if_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        chk("if_pc_next", if_pc_next, e.pc_next);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_seq [3];
    pc_seq[0] = 32'd1;
    pc_seq[1] = 32'd2;
    pc_seq[2] = 32'd2;

    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1: stream from reset
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i));
    @(negedge clk);
    chk("t1_valid_late", {31'b0, if_valid}, 32'd0);
    wait_q(0, 20);
    id_ready = 1'b0;

    // 2: decode stalled from reset
    do_reset();
    chk("t2_imem_pc0", imem_pc, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("t2_imem_pc", imem_pc, pc_seq[k]);
    end
    chk("t2_valid", {31'b0, if_valid}, 32'd1);
    chk("t2_hold_pc", if_pc, 32'd0);
    for (int i = 0; i < 5; i++) push_exp(32'(i));
    id_ready = 1'b1;
    wait_q(0, 20);
    id_ready = 1'b0;

    // 3: redirect while streaming
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i));
    wait_q(1, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd11;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk("t3_valid_gap", {31'b0, if_valid}, 32'd0);
    chk("t3_imem_pc", imem_pc, 32'd11);
    push_exp(32'd11);
    push_exp(32'd12);
    push_exp(32'd13);
    wait_q(0, 20);
    id_ready = 1'b0;

    // 4: redirect while full and stalled
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("t4_full_valid", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk("t4_flushed", {31'b0, if_valid}, 32'd0);
    chk("t4_imem_pc", imem_pc, 32'h40);
    push_exp(32'h40);
    push_exp(32'h41);
    push_exp(32'h42);
    id_ready = 1'b1;
    wait_q(0, 20);
    id_ready = 1'b0;

    // 5: PC wrap
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    id_ready       = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk("t5_imem_pc", imem_pc, 32'hFFFF_FFFF);
    push_exp(32'hFFFF_FFFF);
    push_exp(32'h0);
    push_exp(32'h1);
    wait_q(0, 20);
    id_ready = 1'b0;

    // 6: asynchronous reset mid-stream
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'(i));
    wait_q(0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_imem_pc", imem_pc, 32'd0);
    chk("t6_if_pc", if_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i));
    wait_q(0, 20);
    id_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
